mem_line_ctrl: RTL and testbench

Cache-side bus master that turns whole-line read/write requests into a sequence of single-word transactions on the 18-bit-address / 16-bit-data / 2-bit-command memory bus.
- Sits directly upstream of the memory model and drives its A2/D2/C2 bus.
- Top level ties the split D2/C2 signals to the inout nets.
- Hides per-word memory latency from the cache; returns one full line per request.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_word_xfer.sv | 77 +++++++
 rtl/mem_line_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the 18-bit address / 16-bit data / 2-bit command memory bus
// and the line controller state machine.
package mem_bus_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        RESP  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_word_xfer.sv
// Single-word bus sequencer: owns A2/D2/C2 and, when MEM_TIMEOUT_EN is defined,
// the per-word WAIT-cycle counter.
module mem_word_xfer #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_we,
    input  logic              in_cmd,
    input  logic              in_wait,
    input  logic [1:0]        C2_i,
    output logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] D2_o,
    output logic              D2_oe,
    output logic [1:0]        C2_o,
    output logic              C2_oe,
    output logic              word_ok,
    output logic              word_tmo
);
    import mem_bus_pkg::*;

    logic we_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A2   <= '0;
            D2_o <= '0;
        end else if (load) begin
            A2   <= load_addr;
            D2_o <= load_we ? load_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            we_r <= load_we;
        end
    end

    // Enables come straight from the controller state so an asynchronous
    // reset releases the bus in the same cycle.
    always_comb begin
        C2_oe   = in_cmd;
        C2_o    = in_cmd ? (we_r ? WRITE : READ) : NOP;
        D2_oe   = we_r && (in_cmd || in_wait);
        word_ok = in_wait && (C2_i == RESP);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_wait) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign word_tmo = in_wait && !word_ok && (wait_cnt == CNT_W'(TIMEOUT));
`else
    assign word_tmo = 1'b0;
`endif

endmodule

// File: rtl/mem_line_ctrl.sv
// Line-to-word bus master: splits whole-line requests into single-word bus transfers.
// Optional per-word timeout with MEM_TIMEOUT_EN.
module mem_line_ctrl #(
    parameter int ADDR_W     = mem_bus_pkg::ADDR_W,
    parameter int DATA_W     = mem_bus_pkg::DATA_W,
    parameter int LINE_BYTES = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_W-1:0]       A2,
    output logic [DATA_W-1:0]       D2_o,
    output logic                    D2_oe,
    input  logic [DATA_W-1:0]       D2_i,
    output logic [1:0]              C2_o,
    output logic                    C2_oe,
    input  logic [1:0]              C2_i
);
    import mem_bus_pkg::*;

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WORDS  = LINE_W / DATA_W;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BPW    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic               last;
    logic [ADDR_W-1:0]  base_r;
    logic               we_r;
    logic [LINE_W-1:0]  wdata_r;
    logic [LINE_W-1:0]  rdata_r;

    logic               load;
    logic [ADDR_W-1:0]  load_addr;
    logic [DATA_W-1:0]  load_data;
    logic               load_we;
    logic               word_ok;
    logic               word_tmo;

    assign idx_inc = idx + 1'b1;
    assign last    = (idx == IDX_W'(WORDS - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_addr = base_r;
        load_data = wdata_r[0 +: DATA_W];
        load_we   = we_r;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = CMD;
                    load      = 1'b1;
                    load_addr = req_addr & LINE_MASK;
                    load_data = req_wdata[0 +: DATA_W];
                    load_we   = req_we;
                end
            end
            CMD: state_nxt = WAIT;
            WAIT: begin
                if (word_ok) begin
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        // Next word is issued straight from the RESP cycle.
                        state_nxt = CMD;
                        load      = 1'b1;
                        load_addr = base_r + ADDR_W'(idx_inc) * ADDR_W'(BPW);
                        load_data = wdata_r[idx_inc * DATA_W +: DATA_W];
                    end
                end else if (word_tmo) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            idx     <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx <= '0;
                    end
                end
                WAIT: begin
                    if (word_ok) begin
                        if (!we_r) begin
                            rdata_r[idx * DATA_W +: DATA_W] <= D2_i;
                        end
                        if (!last) begin
                            idx <= idx_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Request payload is only consumed after an accept, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && req_valid) begin
            base_r  <= req_addr & LINE_MASK;
            we_r    <= req_we;
            wdata_r <= req_wdata;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic err_r;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            err_r <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            err_r <= 1'b0;
        end else if (state == WAIT && word_tmo) begin
            err_r <= 1'b1;
        end
    end

    assign resp_err = err_r;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_rdata = rdata_r;

    mem_word_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT (TIMEOUT)
`endif
    ) u_xfer (
        .clk       (CLK),
        .rst_n     (Reset),
        .load      (load),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_we   (load_we),
        .in_cmd    (state == CMD),
        .in_wait   (state == WAIT),
        .C2_i      (C2_i),
        .A2        (A2),
        .D2_o      (D2_o),
        .D2_oe     (D2_oe),
        .C2_o      (C2_o),
        .C2_oe     (C2_oe),
        .word_ok   (word_ok),
        .word_tmo  (word_tmo)
    );

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: line request table plus reset and timeout sequences,
// against a bus responder that answers a fixed number of WAIT cycles after each command.
`timescale 1ns/1ps
module tb_mem_line_ctrl;

    localparam logic [1:0] C_NOP   = 2'd0;
    localparam logic [1:0] C_RESP  = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_WRITE = 2'd3;
    localparam int LIMIT = 2000;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [17:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         resp_err;
    logic [17:0]  A2;
    logic [15:0]  D2_o;
    logic         D2_oe;
    logic [15:0]  D2_i;
    logic [1:0]   C2_o;
    logic         C2_oe;
    logic [1:0]   C2_i;

    mem_line_ctrl #(
        .ADDR_W     (18),
        .DATA_W     (16),
        .LINE_BYTES (16),
        .TIMEOUT    (64)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .A2         (A2),
        .D2_o       (D2_o),
        .D2_oe      (D2_oe),
        .D2_i       (D2_i),
        .C2_o       (C2_o),
        .C2_oe      (C2_oe),
        .C2_i       (C2_i)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder controls and command log
    bit          rsp_en    = 1'b1;
    int          rsp_w     = 1;
    logic [15:0] rsp_key   = 16'h0000;
    bit          rsp_force = 1'b0;
    int          n_cmds    = 0;
    int          hold_bad  = 0;
    logic [17:0] cmd_addr [32];
    logic [1:0]  cmd_op   [32];
    logic [15:0] cmd_data [32];
    logic        cmd_doe  [32];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory-side responder: logs each command, checks the bus is held during WAIT,
    // and drives RESP on the rsp_w-th WAIT cycle with data 0x1111*(word+1) ^ key.
    initial begin
        bit          pend;
        bit          abort;
        bit          we_c;
        logic [17:0] a_hold;
        logic [15:0] d_hold;
        pend = 1'b0;
        C2_i = C_NOP;
        D2_i = '0;
        forever begin
            if (!pend) begin
                @(posedge CLK);
                #1;
            end
            pend = 1'b0;
            if (Reset === 1'b1 && C2_oe === 1'b1 && n_cmds < 32) begin
                cmd_addr[n_cmds] = A2;
                cmd_op[n_cmds]   = C2_o;
                cmd_data[n_cmds] = D2_o;
                cmd_doe[n_cmds]  = D2_oe;
                n_cmds++;
                a_hold = A2;
                d_hold = D2_o;
                we_c   = (C2_o == C_WRITE);
                if (rsp_en) begin
                    if (rsp_force) begin
                        C2_i = C_RESP;
                        D2_i = 16'hDEAD;
                    end
                    abort = 1'b0;
                    for (int k = 1; k <= rsp_w && !abort; k++) begin
                        @(posedge CLK);
                        #1;
                        C2_i = C_NOP;
                        D2_i = '0;
                        if (Reset !== 1'b1) begin
                            abort = 1'b1;
                        end else begin
                            if (C2_oe !== 1'b0 || A2 !== a_hold || D2_oe !== we_c ||
                                (we_c && D2_o !== d_hold))
                                hold_bad++;
                            if (k == rsp_w) begin
                                C2_i = C_RESP;
                                D2_i = (16'h1111 * (16'(A2[3:1]) + 16'd1)) ^ rsp_key;
                            end
                        end
                    end
                    if (!abort) begin
                        @(posedge CLK);
                        #1;
                        C2_i = C_NOP;
                        D2_i = '0;
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    // Issue one line request and wait (bounded) for resp_valid. lat counts clock edges
    // from the accepting edge to the edge that samples resp_valid high, -1 if none.
    task automatic run_line(input bit we, input logic [17:0] addr, input logic [127:0] wdata,
                            input bit hold, output int lat, output logic [127:0] rdata,
                            output logic err, output int reacc, output bit pulse_ok,
                            output logic bus_busy);
        int n;
        bit got;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge CLK);
        #1;
        if (!hold) req_valid = 1'b0;
        n = 0;
        got = 1'b0;
        reacc = 0;
        while (!got && n < LIMIT) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                if (req_ready !== 1'b0) reacc++;
                @(posedge CLK);
                n++;
            end
        end
        req_valid = 1'b0;
        rdata     = resp_rdata;
        err       = resp_err;
        bus_busy  = C2_oe | D2_oe;
        lat       = got ? n + 1 : -1;
        @(negedge CLK);
        pulse_ok  = (resp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    typedef struct {
        bit           we;
        logic [17:0]  addr;
        logic [127:0] wdata;
        int           w;
        logic [15:0]  key;
        bit           hold;
        bit           frc;
        logic [17:0]  exp_a0;
        logic [127:0] exp_rdata;
        int           exp_lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int           lat;
        logic [127:0] rd;
        logic         err;
        int           reacc;
        bit           pulse;
        logic         busy;
        int           cnt;
        logic [127:0] wtmp;

        tbl[0] = '{we: 1'b0, addr: 18'h00010, wdata: 128'h0, w: 5, key: 16'h0000,
                   hold: 1'b0, frc: 1'b0, exp_a0: 18'h00010,
                   exp_rdata: 128'h8888_7777_6666_5555_4444_3333_2222_1111, exp_lat: 49};
        tbl[1] = '{we: 1'b1, addr: 18'h3FFF0,
                   wdata: 128'hA007_A006_A005_A004_A003_A002_A001_A000, w: 2, key: 16'h0000,
                   hold: 1'b0, frc: 1'b0, exp_a0: 18'h3FFF0,
                   exp_rdata: 128'h8888_7777_6666_5555_4444_3333_2222_1111, exp_lat: 25};
        tbl[2] = '{we: 1'b0, addr: 18'h00017, wdata: 128'h0, w: 1, key: 16'h0F0F,
                   hold: 1'b1, frc: 1'b1, exp_a0: 18'h00010,
                   exp_rdata: 128'h8787_7878_6969_5A5A_4B4B_3C3C_2D2D_1E1E, exp_lat: 17};
        tbl[3] = '{we: 1'b0, addr: 18'h2A5AC, wdata: 128'h0, w: 3, key: 16'hFFFF,
                   hold: 1'b0, frc: 1'b0, exp_a0: 18'h2A5A0,
                   exp_rdata: 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, exp_lat: 33};

        Reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Asynchronous reset asserted between clock edges
        #2 Reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_A2", A2, 0);
        chk("rst_D2_o", D2_o, 0);
        chk("rst_D2_oe", D2_oe, 0);
        chk("rst_C2", {C2_oe, C2_o}, {1'b0, C_NOP});
        repeat (3) @(negedge CLK);
        Reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            n_cmds    = 0;
            hold_bad  = 0;
            rsp_en    = 1'b1;
            rsp_w     = tbl[i].w;
            rsp_key   = tbl[i].key;
            rsp_force = tbl[i].frc;
            chk($sformatf("v%0d_ready_idle", i), req_ready, 1);
            run_line(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, lat, rd, err, reacc,
                     pulse, busy);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("v%0d_err", i), err, 0);
            chk($sformatf("v%0d_bus_idle_done", i), busy, 0);
            chk($sformatf("v%0d_pulse_1cyc", i), pulse, 1);
            chk($sformatf("v%0d_no_reaccept", i), reacc, 0);
            chk($sformatf("v%0d_wait_hold", i), hold_bad, 0);
            chk($sformatf("v%0d_ncmds", i), n_cmds, 8);
            wtmp = tbl[i].wdata;
            for (int j = 0; j < 8 && j < n_cmds; j++) begin
                chk($sformatf("v%0d_cmd%0d_addr", i, j), cmd_addr[j], tbl[i].exp_a0 + 18'(2 * j));
                chk($sformatf("v%0d_cmd%0d_op", i, j), {cmd_doe[j], cmd_op[j]},
                    {tbl[i].we, tbl[i].we ? C_WRITE : C_READ});
                if (tbl[i].we)
                    chk($sformatf("v%0d_cmd%0d_data", i, j), cmd_data[j], wtmp[16*j +: 16]);
            end
        end
        rsp_force = 1'b0;

        // Reset during WAIT of word 3 of a write
        n_cmds   = 0;
        hold_bad = 0;
        rsp_w    = 3;
        rsp_key  = 16'h0000;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 18'h00040;
        req_wdata = 128'h5007_5006_5005_5004_5003_5002_5001_5000;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        cnt = 0;
        while (n_cmds < 4 && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        chk("rst_mid_reach_word3", n_cmds, 4);
        @(posedge CLK);
        #1;
        chk("rst_mid_pre_doe", {D2_oe, D2_o}, {1'b1, 16'h5003});
        #1 Reset = 1'b0;
        #1;
        chk("rst_mid_oe", {C2_oe, D2_oe}, 2'b00);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_ready", req_ready, 1);
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        chk("rst_mid_rdata_clr", resp_rdata, 0);
        n_cmds   = 0;
        hold_bad = 0;
        rsp_w    = 1;
        run_line(1'b0, 18'h00048, 128'h0, 1'b0, lat, rd, err, reacc, pulse, busy);
        chk("post_rst_first_A2", cmd_addr[0], 18'h00040);
        chk("post_rst_latency", lat, 17);
        chk("post_rst_rdata", rd, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        chk("post_rst_ncmds", n_cmds, 8);

        // Silent responder
        n_cmds = 0;
        rsp_en = 1'b0;
`ifdef MEM_TIMEOUT_EN
        run_line(1'b0, 18'h00100, 128'h0, 1'b0, lat, rd, err, reacc, pulse, busy);
        chk("tmo_latency", lat, 67);
        chk("tmo_err", err, 1);
        chk("tmo_bus_released", busy, 0);
        chk("tmo_rdata_kept", rd, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        chk("tmo_ncmds", n_cmds, 1);
        n_cmds = 0;
        rsp_en = 1'b1;
        rsp_w  = 2;
        run_line(1'b0, 18'h00200, 128'h0, 1'b0, lat, rd, err, reacc, pulse, busy);
        chk("tmo_next_err_clr", err, 0);
        chk("tmo_next_latency", lat, 25);
`else
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 18'h00100;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        begin
            bit seen_valid;
            bit seen_ready;
            bit seen_err;
            bit seen_c2oe;
            seen_valid = 1'b0;
            seen_ready = 1'b0;
            seen_err   = 1'b0;
            seen_c2oe  = 1'b0;
            repeat (2) @(negedge CLK);
            repeat (1000) begin
                @(negedge CLK);
                seen_valid |= (resp_valid !== 1'b0);
                seen_ready |= (req_ready !== 1'b0);
                seen_err   |= (resp_err !== 1'b0);
                seen_c2oe  |= (C2_oe !== 1'b0);
            end
            chk("hang_no_resp_valid", seen_valid, 0);
            chk("hang_not_ready", seen_ready, 0);
            chk("hang_err_zero", seen_err, 0);
            chk("hang_c2_released", seen_c2oe, 0);
            chk("hang_ncmds", n_cmds, 1);
        end
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        chk("hang_recover_ready", req_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
